mvm_bn_res_sched: RTL and testbench
===================================

Name: mvm_bn_res_sched

Overview:
- Tile scheduler for the HBM MVM + BN + residual-add output stage.
- Walks output channel groups (CHout/Tout), then rows and columns within each group.
- Per group, issues one BN weight/bias fetch command. Per pixel, issues one residual-fetch command and one output-write command.
- Limits in-flight output writes, and fences BN reloads until every write of the group is acknowledged.

Parameters:
- ADDR_W, 32, address width of all base/stride/command addresses
- CNT_W, 16, width of group/row/column counters
- PIX_BYTES, 64, bytes per output pixel word (w step)
- BN_STRIDE, 64, BN bytes per channel group
- MAX_OUTSTANDING, 4, maximum out writes accepted but not yet acked

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle launch pulse; ignored while busy
- cfg_ch_groups  in  CNT_W  number of Tout channel groups
- cfg_h  in  CNT_W  output rows
- cfg_w  in  CNT_W  output columns
- cfg_res_en  in  1  residual add enabled
- cfg_bn_base, cfg_res_base, cfg_out_base  in  ADDR_W  base addresses
- cfg_res_surface, cfg_res_line, cfg_out_surface, cfg_out_line  in  ADDR_W  strides
- bn_req_valid/bn_req_ready  out/in  1  BN fetch handshake
- bn_req_addr  out  ADDR_W  BN fetch address
- bn_done  in  1  pulse: BN params loaded into datapath
- res_req_valid/res_req_ready  out/in  1  residual fetch handshake
- res_req_addr  out  ADDR_W  residual fetch address
- out_req_valid/out_req_ready  out/in  1  output write handshake
- out_req_addr  out  ADDR_W  output write address
- out_ack  in  1  pulse: one output pixel written
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset: all valids, busy and done low; all addrs 0; FSM IDLE; counters 0.
- Reset mid-operation aborts immediately. In-flight bn_done/out_ack pulses arriving after reset are ignored.
- All cfg_* inputs are latched on an accepted start. Later cfg changes have no effect on the running job.
- FSM states: IDLE, BN_REQ, BN_WAIT, PIX, DRAIN, DONE.
- IDLE: on start, if any of ch_groups, h, w is 0 → DONE; otherwise → BN_REQ with g=0. busy rises the cycle after start.
- BN_REQ: bn_req_valid=1, bn_req_addr = bn_base + g*BN_STRIDE. Valid and addr are held stable until ready; on handshake → BN_WAIT.
- BN_WAIT: wait for bn_done → PIX, with the res and out pixel counters reset to (h=0, w=0).
- PIX, residual stream:
  - Only when res_en.
  - res_req_addr = res_base + g*res_surface + h*res_line + w*PIX_BYTES.
  - Runs independently of the out stream.
  - Stops after cfg_h*cfg_w accepted requests.
- PIX, output stream:
  - out_req_addr = out_base + g*out_surface + h*out_line + w*PIX_BYTES.
  - out_req_valid for pixel k requires outstanding < MAX_OUTSTANDING.
  - When res_en, it additionally requires res pixel k already accepted (in a prior cycle, or in the same cycle).
- Pixel counter order: w increments first; at w = cfg_w-1, w wraps to 0 and h increments.
- Valid/addr stability: once raised, a valid and its addr hold until the matching ready, even if outstanding changes.
- outstanding counter:
  - +1 on out handshake, −1 on out_ack; simultaneous events → unchanged.
  - out_ack while outstanding = 0 is ignored (counter saturates at 0).
- All out pixels of the group accepted → DRAIN.
- DRAIN: wait for outstanding = 0. Then, if g < ch_groups-1: g++ → BN_REQ; otherwise → DONE.
- DONE: done=1 for exactly one cycle, busy drops the same cycle, → IDLE. A new start is accepted the cycle after done.
- Address arithmetic: unsigned, modulo 2^ADDR_W; products truncated to ADDR_W.
- Throughput: one res and one out handshake per cycle when ready is held high and credit is available.

Test Plan:
- Basic: groups=1, h=1, w=1, res_en=1, bases bn=0x400_0000, res=0x600_0000, out=0x800_0000, all readies high, bn_done and out_ack each returned 1 cycle after request → exactly one BN/res/out request each at those addresses; done one cycle after out_ack; busy high throughout.
- Addressing: groups=2, h=3, w=2, surface=0x180, line=0x80 → out addrs base+{0,0x40,0x80,0xC0,0x100,0x140}, then +0x180 for g=1; second bn_req at bn_base+64, only after 6 out_acks.
- Backpressure: random ready deassertion on all three channels → valids never drop and addrs never change before handshake; per-group res and out counts are each h*w.
- Credit limit: out_ack withheld → exactly 4 out handshakes, out_req_valid then stays low. A single out_ack releases exactly one more. Simultaneous handshake + ack leaves outstanding unchanged.
- res_en=0 → no res_req_valid ever; out stream gated only by credit; addresses as in the addressing test.
- Corners: cfg_w=0 → done 1 cycle after start, no requests. start pulsed while busy → ignored. rst asserted in PIX → all outputs 0 the next cycle; a stale out_ack is ignored; a fresh start runs normally.

Source files
------------

// File: rtl/mvm_bn_res_sched.sv
// Output-stage tile scheduler: per channel group one BN fetch, then per pixel one residual
// fetch and one output write, with a credit limit on unacknowledged writes and a BN fence.
module mvm_bn_res_sched #(
    parameter int ADDR_W          = 32,
    parameter int CNT_W           = 16,
    parameter int PIX_BYTES       = 64,
    parameter int BN_STRIDE       = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_ch_groups,
    input  logic [CNT_W-1:0]  cfg_h,
    input  logic [CNT_W-1:0]  cfg_w,
    input  logic              cfg_res_en,
    input  logic [ADDR_W-1:0] cfg_bn_base,
    input  logic [ADDR_W-1:0] cfg_res_base,
    input  logic [ADDR_W-1:0] cfg_out_base,
    input  logic [ADDR_W-1:0] cfg_res_surface,
    input  logic [ADDR_W-1:0] cfg_res_line,
    input  logic [ADDR_W-1:0] cfg_out_surface,
    input  logic [ADDR_W-1:0] cfg_out_line,
    output logic              bn_req_valid,
    input  logic              bn_req_ready,
    output logic [ADDR_W-1:0] bn_req_addr,
    input  logic              bn_done,
    output logic              res_req_valid,
    input  logic              res_req_ready,
    output logic [ADDR_W-1:0] res_req_addr,
    output logic              out_req_valid,
    input  logic              out_req_ready,
    output logic [ADDR_W-1:0] out_req_addr,
    input  logic              out_ack,
    output logic              busy,
    output logic              done
);
    localparam int PW = 2 * CNT_W;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [2:0] {S_IDLE, S_BN_REQ, S_BN_WAIT, S_PIX, S_DRAIN, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  g_q, g_d, groups_q, groups_d, h_q, h_d, w_q, w_d;
    logic              res_en_q, res_en_d;
    logic [ADDR_W-1:0] bn_base_q, bn_base_d, res_base_q, res_base_d, out_base_q, out_base_d;
    logic [ADDR_W-1:0] res_surf_q, res_surf_d, res_line_q, res_line_d;
    logic [ADDR_W-1:0] out_surf_q, out_surf_d, out_line_q, out_line_d;
    logic [PW-1:0]     total_q, total_d, res_cnt_q, res_cnt_d, out_cnt_q, out_cnt_d;
    logic [CNT_W-1:0]  res_h_q, res_h_d, res_w_q, res_w_d, out_h_q, out_h_d, out_w_q, out_w_d;
    logic              res_vld_q, res_vld_d, out_vld_q, out_vld_d;
    logic [OW-1:0]     outst_q, outst_d;
    logic              res_hs, out_hs, ack_ok;

    always_comb begin
        state_d    = state_q;
        g_d        = g_q;
        groups_d   = groups_q;
        h_d        = h_q;
        w_d        = w_q;
        res_en_d   = res_en_q;
        bn_base_d  = bn_base_q;
        res_base_d = res_base_q;
        out_base_d = out_base_q;
        res_surf_d = res_surf_q;
        res_line_d = res_line_q;
        out_surf_d = out_surf_q;
        out_line_d = out_line_q;
        total_d    = total_q;
        res_cnt_d  = res_cnt_q;
        out_cnt_d  = out_cnt_q;
        res_h_d    = res_h_q;
        res_w_d    = res_w_q;
        out_h_d    = out_h_q;
        out_w_d    = out_w_q;
        outst_d    = outst_q;

        res_hs = res_vld_q && res_req_ready;
        out_hs = out_vld_q && out_req_ready;
        // An ack with nothing outstanding is stale (e.g. from before a reset) and is dropped.
        ack_ok = out_ack && (outst_q != '0);
        if (out_hs && !ack_ok) begin
            outst_d = outst_q + OW'(1);
        end else if (!out_hs && ack_ok) begin
            outst_d = outst_q - OW'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    groups_d   = cfg_ch_groups;
                    h_d        = cfg_h;
                    w_d        = cfg_w;
                    res_en_d   = cfg_res_en;
                    bn_base_d  = cfg_bn_base;
                    res_base_d = cfg_res_base;
                    out_base_d = cfg_out_base;
                    res_surf_d = cfg_res_surface;
                    res_line_d = cfg_res_line;
                    out_surf_d = cfg_out_surface;
                    out_line_d = cfg_out_line;
                    total_d    = PW'(cfg_h) * PW'(cfg_w);
                    g_d        = '0;
                    if (cfg_ch_groups == '0 || cfg_h == '0 || cfg_w == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_BN_REQ;
                    end
                end
            end
            S_BN_REQ: begin
                if (bn_req_ready) begin
                    state_d = S_BN_WAIT;
                end
            end
            S_BN_WAIT: begin
                if (bn_done) begin
                    state_d   = S_PIX;
                    res_cnt_d = '0;
                    out_cnt_d = '0;
                    res_h_d   = '0;
                    res_w_d   = '0;
                    out_h_d   = '0;
                    out_w_d   = '0;
                end
            end
            S_PIX: begin
                if (res_hs) begin
                    res_cnt_d = res_cnt_q + PW'(1);
                    if (res_w_q == w_q - CNT_W'(1)) begin
                        res_w_d = '0;
                        res_h_d = res_h_q + CNT_W'(1);
                    end else begin
                        res_w_d = res_w_q + CNT_W'(1);
                    end
                end
                if (out_hs) begin
                    out_cnt_d = out_cnt_q + PW'(1);
                    if (out_w_q == w_q - CNT_W'(1)) begin
                        out_w_d = '0;
                        out_h_d = out_h_q + CNT_W'(1);
                    end else begin
                        out_w_d = out_w_q + CNT_W'(1);
                    end
                end
                if (out_cnt_d == total_q) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // BN parameters may only be replaced once every write of this group has landed.
                if (outst_d == '0) begin
                    if ((g_q + CNT_W'(1)) < groups_q) begin
                        g_d     = g_q + CNT_W'(1);
                        state_d = S_BN_REQ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Valids are registered; a pending request holds until its handshake.
        res_vld_d = (state_d == S_PIX) && res_en_q && (res_cnt_d < total_q);
        out_vld_d = (state_d == S_PIX) && (out_cnt_d < total_q) &&
                    ((out_vld_q && !out_hs) ||
                     ((outst_d < OW'(MAX_OUTSTANDING)) && (!res_en_q || (res_cnt_d > out_cnt_d))));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            g_q        <= '0;
            groups_q   <= '0;
            h_q        <= '0;
            w_q        <= '0;
            res_en_q   <= 1'b0;
            bn_base_q  <= '0;
            res_base_q <= '0;
            out_base_q <= '0;
            res_surf_q <= '0;
            res_line_q <= '0;
            out_surf_q <= '0;
            out_line_q <= '0;
            total_q    <= '0;
            res_cnt_q  <= '0;
            out_cnt_q  <= '0;
            res_h_q    <= '0;
            res_w_q    <= '0;
            out_h_q    <= '0;
            out_w_q    <= '0;
            res_vld_q  <= 1'b0;
            out_vld_q  <= 1'b0;
            outst_q    <= '0;
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            groups_q   <= groups_d;
            h_q        <= h_d;
            w_q        <= w_d;
            res_en_q   <= res_en_d;
            bn_base_q  <= bn_base_d;
            res_base_q <= res_base_d;
            out_base_q <= out_base_d;
            res_surf_q <= res_surf_d;
            res_line_q <= res_line_d;
            out_surf_q <= out_surf_d;
            out_line_q <= out_line_d;
            total_q    <= total_d;
            res_cnt_q  <= res_cnt_d;
            out_cnt_q  <= out_cnt_d;
            res_h_q    <= res_h_d;
            res_w_q    <= res_w_d;
            out_h_q    <= out_h_d;
            out_w_q    <= out_w_d;
            res_vld_q  <= res_vld_d;
            out_vld_q  <= out_vld_d;
            outst_q    <= outst_d;
        end
    end

    // Addresses derive from registers that only move on a handshake, so they stay stable while stalled.
    assign bn_req_addr  = bn_base_q + ADDR_W'(g_q) * ADDR_W'(BN_STRIDE);
    assign res_req_addr = res_base_q + ADDR_W'(g_q) * res_surf_q + ADDR_W'(res_h_q) * res_line_q
                        + ADDR_W'(res_w_q) * ADDR_W'(PIX_BYTES);
    assign out_req_addr = out_base_q + ADDR_W'(g_q) * out_surf_q + ADDR_W'(out_h_q) * out_line_q
                        + ADDR_W'(out_w_q) * ADDR_W'(PIX_BYTES);

    assign bn_req_valid  = (state_q == S_BN_REQ);
    assign res_req_valid = res_vld_q;
    assign out_req_valid = out_vld_q;
    assign busy = (state_q == S_BN_REQ) || (state_q == S_BN_WAIT) ||
                  (state_q == S_PIX) || (state_q == S_DRAIN);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_mvm_bn_res_sched.sv
// Scoreboard bench for mvm_bn_res_sched: expected request addresses are queued per job and
// popped on every handshake; a responder models BN/ack returns, credit, fencing and stability.
module tb_mvm_bn_res_sched;
    localparam logic [31:0] BN_B  = 32'h0400_0000;
    localparam logic [31:0] RES_B = 32'h0600_0000;
    localparam logic [31:0] OUT_B = 32'h0800_0000;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [15:0] cfg_ch_groups, cfg_h, cfg_w;
    logic        cfg_res_en;
    logic [31:0] cfg_bn_base, cfg_res_base, cfg_out_base;
    logic [31:0] cfg_res_surface, cfg_res_line, cfg_out_surface, cfg_out_line;
    logic        bn_req_valid, bn_req_ready, bn_done;
    logic        res_req_valid, res_req_ready, out_req_valid, out_req_ready, out_ack;
    logic [31:0] bn_req_addr, res_req_addr, out_req_addr;
    logic        busy, done;

    always #5 clk = ~clk;

    mvm_bn_res_sched dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_ch_groups(cfg_ch_groups), .cfg_h(cfg_h), .cfg_w(cfg_w), .cfg_res_en(cfg_res_en),
        .cfg_bn_base(cfg_bn_base), .cfg_res_base(cfg_res_base), .cfg_out_base(cfg_out_base),
        .cfg_res_surface(cfg_res_surface), .cfg_res_line(cfg_res_line),
        .cfg_out_surface(cfg_out_surface), .cfg_out_line(cfg_out_line),
        .bn_req_valid(bn_req_valid), .bn_req_ready(bn_req_ready), .bn_req_addr(bn_req_addr),
        .bn_done(bn_done),
        .res_req_valid(res_req_valid), .res_req_ready(res_req_ready), .res_req_addr(res_req_addr),
        .out_req_valid(out_req_valid), .out_req_ready(out_req_ready), .out_req_addr(out_req_addr),
        .out_ack(out_ack), .busy(busy), .done(done)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [31:0] q_bn[$], q_res[$], q_out[$];

    bit rand_rdy = 0, rand_ack = 0, ack_hold = 0, job_res_en = 0, job_active = 0;
    bit stale_ack_req = 0, stale_bn_req = 0;
    int ack_release = 0;
    int cyc = 0, done_cyc = 0, done_cnt = 0, last_ack_cyc = 0;
    int mdl_out = 0, mdl_pre = 0, ack_pend = 0, bn_pend = 0;
    int hs_out_total = 0, grp_res = 0, grp_out = 0, res_vld_seen = 0, busy_low = 0, d_snap = 0;
    bit p_bn_stall = 0, p_res_stall = 0, p_out_stall = 0;
    logic [31:0] p_bn_addr, p_res_addr, p_out_addr;

    // Responder: drives readies, bn_done and out_ack, and checks every handshake.
    initial begin
        bn_req_ready = 1'b0; res_req_ready = 1'b0; out_req_ready = 1'b0;
        bn_done = 1'b0; out_ack = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            if (rst) begin
                bn_done = 1'b0; out_ack = 1'b0;
                mdl_out = 0; ack_pend = 0; bn_pend = 0; grp_res = 0; grp_out = 0;
                p_bn_stall = 0; p_res_stall = 0; p_out_stall = 0;
            end else begin
                if (p_bn_stall) begin
                    chk("bn_hold_vld", bn_req_valid, 1); chk("bn_hold_addr", bn_req_addr, p_bn_addr);
                end
                if (p_res_stall) begin
                    chk("res_hold_vld", res_req_valid, 1); chk("res_hold_addr", res_req_addr, p_res_addr);
                end
                if (p_out_stall) begin
                    chk("out_hold_vld", out_req_valid, 1); chk("out_hold_addr", out_req_addr, p_out_addr);
                end
                bn_req_ready  = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
                res_req_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
                out_req_ready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
                bn_done = 1'b0;
                if (stale_bn_req) begin
                    bn_done = 1'b1; stale_bn_req = 0;
                end else if (bn_pend > 0) begin
                    bn_done = 1'b1; bn_pend = 0;
                end
                mdl_pre = mdl_out;
                out_ack = 1'b0;
                if (stale_ack_req) begin
                    out_ack = 1'b1; stale_ack_req = 0;
                end else if (ack_pend > 0 && (!ack_hold || ack_release > 0) &&
                             (!rand_ack || $urandom_range(0, 1) == 1)) begin
                    out_ack = 1'b1; ack_pend--; mdl_out--; last_ack_cyc = cyc;
                    if (ack_release > 0) ack_release--;
                end
                if (bn_req_valid && bn_req_ready) begin
                    chk("bn_fence", mdl_pre, 0);
                    chk("bn_expected", q_bn.size() != 0, 1);
                    if (q_bn.size() != 0) chk("bn_addr", bn_req_addr, q_bn.pop_front());
                    bn_pend = 1; grp_res = 0; grp_out = 0;
                end
                if (res_req_valid) res_vld_seen++;
                if (res_req_valid && res_req_ready) begin
                    chk("res_expected", q_res.size() != 0, 1);
                    if (q_res.size() != 0) chk("res_addr", res_req_addr, q_res.pop_front());
                    grp_res++;
                end
                if (out_req_valid && out_req_ready) begin
                    chk("out_credit", mdl_pre < 4, 1);
                    if (job_res_en) chk("out_after_res", grp_res > grp_out, 1);
                    chk("out_expected", q_out.size() != 0, 1);
                    if (q_out.size() != 0) chk("out_addr", out_req_addr, q_out.pop_front());
                    grp_out++; hs_out_total++; ack_pend++; mdl_out++;
                end
                if (job_active && !done && !busy) busy_low++;
                if (done) begin
                    done_cnt++; done_cyc = cyc; job_active = 0;
                end
                p_bn_stall = bn_req_valid && !bn_req_ready;   p_bn_addr  = bn_req_addr;
                p_res_stall = res_req_valid && !res_req_ready; p_res_addr = res_req_addr;
                p_out_stall = out_req_valid && !out_req_ready; p_out_addr = out_req_addr;
            end
        end
    end

    task automatic set_job(input int gr, input int h, input int w, input bit ren,
                           input logic [31:0] rs, input logic [31:0] rl,
                           input logic [31:0] os, input logic [31:0] ol);
        logic [31:0] a;
        cfg_ch_groups = 16'(gr); cfg_h = 16'(h); cfg_w = 16'(w); cfg_res_en = ren;
        cfg_bn_base = BN_B; cfg_res_base = RES_B; cfg_out_base = OUT_B;
        cfg_res_surface = rs; cfg_res_line = rl; cfg_out_surface = os; cfg_out_line = ol;
        job_res_en = ren;
        if (h == 0 || w == 0) return;
        for (int g = 0; g < gr; g++) begin
            a = BN_B + 32'(g) * 32'd64;
            q_bn.push_back(a);
            for (int y = 0; y < h; y++) begin
                for (int x = 0; x < w; x++) begin
                    if (ren) begin
                        a = RES_B + 32'(g) * rs + 32'(y) * rl + 32'(x) * 32'd64;
                        q_res.push_back(a);
                    end
                    a = OUT_B + 32'(g) * os + 32'(y) * ol + 32'(x) * 32'd64;
                    q_out.push_back(a);
                end
            end
        end
    endtask

    task automatic start_job();
        d_snap = done_cnt; busy_low = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; job_active = 1;
    endtask

    task automatic wait_done(input bit poke);
        int t = 0;
        while (done_cnt == d_snap && t < 3000) begin
            @(negedge clk);
            t++;
            if (poke && t == 8) begin
                start = 1'b1; cfg_w = 16'd7; cfg_h = 16'd5; cfg_out_base = 32'h1234_0000;
            end
            if (poke && t == 9) start = 1'b0;
        end
        chk("done_seen", done_cnt != d_snap, 1);
        repeat (2) @(negedge clk);
        chk("bn_left", q_bn.size(), 0);
        chk("res_left", q_res.size(), 0);
        chk("out_left", q_out.size(), 0);
        chk("busy_hold", busy_low, 0);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_bn_vld"}, bn_req_valid, 0);
        chk({tag, "_res_vld"}, res_req_valid, 0);
        chk({tag, "_out_vld"}, out_req_valid, 0);
        chk({tag, "_bn_addr"}, bn_req_addr, 0);
        chk({tag, "_res_addr"}, res_req_addr, 0);
        chk({tag, "_out_addr"}, out_req_addr, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    initial begin
        int b, rv0, t;
        rst = 1'b1; start = 1'b0;
        set_job(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #2 chk_idle_outputs("reset");

        // Single pixel, single group
        set_job(1, 1, 1, 1, 0, 0, 0, 0);
        start_job();
        wait_done(0);
        chk("done_after_ack", done_cyc, last_ack_cyc + 1);

        // Two groups of 3x2 with surface/line strides
        set_job(2, 3, 2, 1, 32'h180, 32'h80, 32'h180, 32'h80);
        start_job();
        wait_done(0);

        // No residual
        rv0 = res_vld_seen;
        set_job(2, 3, 2, 0, 32'h180, 32'h80, 32'h180, 32'h80);
        start_job();
        wait_done(0);
        chk("no_res_vld", res_vld_seen - rv0, 0);

        // Random backpressure and ack delay, with a start/cfg poke while busy
        rand_rdy = 1; rand_ack = 1;
        set_job(2, 3, 4, 1, 32'h1000, 32'h100, 32'h2000, 32'h200);
        start_job();
        wait_done(1);
        rand_rdy = 0; rand_ack = 0;

        // Credit limit with acks withheld
        ack_hold = 1;
        set_job(1, 2, 4, 0, 32'h0, 32'h100, 32'h0, 32'h100);
        b = hs_out_total;
        start_job();
        repeat (20) @(negedge clk);
        #2 chk("credit_cap", hs_out_total - b, 4);
        chk("credit_vld_low", out_req_valid, 0);
        ack_release = 1;
        repeat (10) @(negedge clk);
        #2 chk("credit_one_more", hs_out_total - b, 5);
        chk("credit_vld_low2", out_req_valid, 0);
        ack_hold = 0;
        wait_done(0);

        // Zero-sized job
        set_job(1, 2, 0, 1, 0, 0, 0, 0);
        b = hs_out_total;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        #2 chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        repeat (3) @(negedge clk);
        chk("zero_no_out", hs_out_total - b, 0);

        // Reset in the middle of PIX, stale pulses afterwards, then a fresh job
        ack_hold = 1;
        set_job(2, 3, 4, 1, 32'h1000, 32'h100, 32'h2000, 32'h200);
        b = hs_out_total;
        start_job();
        t = 0;
        while (hs_out_total - b < 2 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("rst_reached_pix", hs_out_total - b >= 2, 1);
        @(negedge clk); rst = 1'b1; job_active = 0;
        @(negedge clk);
        #2 chk_idle_outputs("midrst");
        @(negedge clk); rst = 1'b0;
        q_bn.delete(); q_res.delete(); q_out.delete();
        ack_hold = 0;
        @(negedge clk); stale_ack_req = 1; stale_bn_req = 1;
        repeat (3) @(negedge clk);
        #2 chk("stale_idle_busy", busy, 0);
        ack_hold = 1;
        set_job(1, 1, 8, 0, 32'h0, 32'h0, 32'h0, 32'h0);
        b = hs_out_total;
        start_job();
        repeat (20) @(negedge clk);
        #2 chk("post_rst_cap", hs_out_total - b, 4);
        ack_hold = 0;
        wait_done(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end
endmodule
